vdp_bus_master: RTL and testbench

Host-side sequencer for the VDP CPU bus. It accepts simple register-write, VRAM-write and VRAM-read commands on a valid/ready interface. For each command it generates the VDP `mode`/`write`/`read`/data waveform, with setup, strobe, hold and VRAM-slot spacing, so that every access is latched exactly once. Sits between the CPU core (or a test harness) and the VDP instance.

---
 rtl/vdp_bus_master.sv | 239 +++++++++++++++++++++++
 tb/tb_vdp_bus_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_bus_master.sv
// ----------------------------------------------------------------------------
// vdp_bus_master
//
// Host-side sequencer for the VDP CPU bus. Takes register-write, VRAM-write,
// VRAM-read and register-select commands on a valid/ready handshake. For each
// one it generates the VDP mode/write/read/data waveform as one or two bus
// phases (SETUP -> STROBE -> HOLD), so the VDP latches every access exactly
// once. VRAM accesses and writes to registers 0-3 are followed by an idle GAP
// that covers one VDP tile slot.
//
// Ports
//   clk        in   system clock, shared with the VDP
//   reset      in   asynchronous, active-high
//   cmd_valid  in   command offered
//   cmd_ready  out  high only in IDLE, low while reset is asserted
//   cmd_op     in   00 reg write, 01 VRAM write, 10 VRAM read, 11 reg select
//   cmd_reg    in   register index (ops 00, 11)
//   cmd_data   in   write data (ops 00, 01)
//   rsp_valid  out  one-cycle pulse carrying VRAM read data
//   rsp_data   out  last VRAM read data, held until the next read
//   busy       out  high whenever the sequencer is not in IDLE
//   vdp_mode   out  VDP mode (11 = bus idle)
//   vdp_write  out  VDP write strobe
//   vdp_read   out  VDP read strobe
//   vdp_wdata  out  VDP data_in
//   vdp_rdata  in   VDP data_out
// ----------------------------------------------------------------------------
module vdp_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int VRAM_GAP      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [1:0] vdp_mode,
    output logic       vdp_write,
    output logic       vdp_read,
    output logic [7:0] vdp_wdata,
    input  logic [7:0] vdp_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_GAP
    } state_t;

    typedef enum logic [1:0] {
        OP_REG_WR  = 2'b00,
        OP_VRAM_WR = 2'b01,
        OP_VRAM_RD = 2'b10,
        OP_REG_SEL = 2'b11
    } op_t;

    localparam int CW = 16;
    // Counters load "length - 1" and the state advances when they reach zero.
    localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(VRAM_GAP - 1);

    localparam logic [1:0] PH_A = 2'd0;  // register select (mode 00)
    localparam logic [1:0] PH_B = 2'd1;  // register data   (mode 01)

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      phase, phase_nxt;
    op_t             op_q, op_nxt;
    logic [3:0]      reg_q, reg_nxt;
    logic [7:0]      data_q, data_nxt;
    logic            sample;
    logic            needs_gap;

    logic [1:0]      mode_nxt;
    logic [7:0]      wdata_nxt;
    logic            write_nxt;
    logic            read_nxt;
    logic            bus_active;

    // Writes to registers 0-3 move the VRAM address/mode, so they get the
    // same slot of quiet time as a real VRAM access.
    assign needs_gap = (op_q == OP_VRAM_WR) || (op_q == OP_VRAM_RD) ||
                       (op_q == OP_REG_WR && reg_q <= 4'd3);

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        phase_nxt = phase;
        op_nxt    = op_q;
        reg_nxt   = reg_q;
        data_nxt  = data_q;
        sample    = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt = S_SETUP;
                    cnt_nxt   = SETUP_LAST;
                    phase_nxt = PH_A;
                    op_nxt    = op_t'(cmd_op);
                    reg_nxt   = cmd_reg;
                    data_nxt  = cmd_data;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nxt = S_STROBE;
                    cnt_nxt   = STROBE_LAST;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt == '0) begin
                    state_nxt = S_HOLD;
                    cnt_nxt   = HOLD_LAST;
                    // Read data is taken on the last strobe cycle, after the
                    // VDP has had the full strobe width to drive it.
                    sample    = (op_q == OP_VRAM_RD);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt == '0) begin
                    if (op_q == OP_REG_WR && phase == PH_A) begin
                        state_nxt = S_SETUP;
                        cnt_nxt   = SETUP_LAST;
                        phase_nxt = PH_B;
                    end else if (needs_gap && VRAM_GAP != 0) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LAST;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so the pins
    // line up with the state and never see a combinational path from cmd_*.
    assign bus_active = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                        (state_nxt == S_HOLD);

    always_comb begin
        mode_nxt  = 2'b11;
        wdata_nxt = 8'h00;
        write_nxt = 1'b0;
        read_nxt  = 1'b0;
        if (bus_active) begin
            case (op_nxt)
                OP_REG_WR, OP_REG_SEL: begin
                    if (phase_nxt == PH_A) begin
                        mode_nxt  = 2'b00;
                        wdata_nxt = {4'b0000, reg_nxt};
                    end else begin
                        mode_nxt  = 2'b01;
                        wdata_nxt = data_nxt;
                    end
                end
                OP_VRAM_WR: begin
                    mode_nxt  = 2'b10;
                    wdata_nxt = data_nxt;
                end
                default: begin
                    mode_nxt  = 2'b10;
                    wdata_nxt = 8'h00;
                end
            endcase
            write_nxt = (state_nxt == S_STROBE) && (op_nxt != OP_VRAM_RD);
            read_nxt  = (state_nxt == S_STROBE) && (op_nxt == OP_VRAM_RD);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // in this block samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= PH_A;
            op_q      <= OP_REG_SEL;
            reg_q     <= 4'h0;
            data_q    <= 8'h00;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            vdp_mode  <= 2'b11;
            vdp_wdata <= 8'h00;
            vdp_write <= 1'b0;
            vdp_read  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            phase     <= phase_nxt;
            op_q      <= op_nxt;
            reg_q     <= reg_nxt;
            data_q    <= data_nxt;
            // Registered from the next state: low through reset, high on the
            // first edge after release, and equal to (state == IDLE) afterwards.
            cmd_ready <= (state_nxt == S_IDLE);
            busy      <= (state_nxt != S_IDLE);
            rsp_valid <= sample;
            if (sample) begin
                rsp_data <= vdp_rdata;
            end
            vdp_mode  <= mode_nxt;
            vdp_wdata <= wdata_nxt;
            vdp_write <= write_nxt;
            vdp_read  <= read_nxt;
        end
    end

endmodule

// File: tb/tb_vdp_bus_master.sv
// ----------------------------------------------------------------------------
// tb_vdp_bus_master
//
// Directed bench for vdp_bus_master. Instance u_dut uses default timing;
// u_dut_p2 uses SETUP_CYCLES=2, STROBE_CYCLES=1. A small VDP stand-in drives
// read data only on the last strobe cycle, and a monitor logs the mode/data
// seen on every falling edge of vdp_write of u_dut.
// ----------------------------------------------------------------------------
module tb_vdp_bus_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       sel = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_reg = 4'h0;
    logic [7:0] cmd_data = 8'h00;

    logic       ready1, rsp_valid1, busy1, write1, read1;
    logic [7:0] rsp_data1, wdata1, rdata1;
    logic [1:0] mode1;
    logic       ready2, rsp_valid2, busy2, write2, read2;
    logic [7:0] rsp_data2, wdata2, rdata2;
    logic [1:0] mode2;
    logic       cmd_ready_sel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vdp_bus_master u_dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid && !sel),
        .cmd_ready (ready1),
        .cmd_op    (cmd_op),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid1),
        .rsp_data  (rsp_data1),
        .busy      (busy1),
        .vdp_mode  (mode1),
        .vdp_write (write1),
        .vdp_read  (read1),
        .vdp_wdata (wdata1),
        .vdp_rdata (rdata1)
    );

    vdp_bus_master #(
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (1),
        .HOLD_CYCLES   (1),
        .VRAM_GAP      (16)
    ) u_dut_p2 (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid && sel),
        .cmd_ready (ready2),
        .cmd_op    (cmd_op),
        .cmd_reg   (cmd_reg),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid2),
        .rsp_data  (rsp_data2),
        .busy      (busy2),
        .vdp_mode  (mode2),
        .vdp_write (write2),
        .vdp_read  (read2),
        .vdp_wdata (wdata2),
        .vdp_rdata (rdata2)
    );

    assign cmd_ready_sel = sel ? ready2 : ready1;

    // VDP stand-in: read data is valid only on the last cycle of the strobe.
    int         rd_len1 = 0;
    int         rd_len2 = 0;
    logic [7:0] rd_val1 = 8'h00;
    logic [7:0] rd_val2 = 8'h00;
    always @(posedge clk) begin
        rd_len1 <= read1 ? rd_len1 + 1 : 0;
        rd_len2 <= read2 ? rd_len2 + 1 : 0;
    end
    assign rdata1 = (read1 && rd_len1 == 1) ? rd_val1 : 8'hEE;
    assign rdata2 = (read2 && rd_len2 == 0) ? rd_val2 : 8'hEE;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        int         at;
    } wr_ev_t;

    wr_ev_t wlog[$];
    logic   prev_w = 1'b0;
    int     rsp_cnt1 = 0, rsp_cnt2 = 0, rsp_at1 = 0, rsp_at2 = 0;
    int     bad_bus = 0;

    // Sampled 1 ns after each edge; "at" is the index of that edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            prev_w = 1'b0;
        end else begin
            if (prev_w && !write1) wlog.push_back('{mode1, wdata1, cyc - 1});
            prev_w = write1;
            if (read1 && write1) bad_bus++;
            if (read1 && wdata1 != 8'h00) bad_bus++;
        end
        if (rsp_valid1) begin rsp_cnt1++; rsp_at1 = cyc - 1; end
        if (rsp_valid2) begin rsp_cnt2++; rsp_at2 = cyc - 1; end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offers one command; returns the acceptance edge index.
    task automatic issue(input logic s, input logic [1:0] op, input logic [3:0] r,
                         input logic [7:0] d, output int acc);
        int n;
        @(negedge clk);
        sel = s; cmd_op = op; cmd_reg = r; cmd_data = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_sel && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("issue_timeout", 32'(n), 32'd0);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc - 1;
        // Scramble the inputs while busy; they must be ignored.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_reg   = 4'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    // Issues a command and checks edges until cmd_ready is high again.
    task automatic run_cmd(input logic s, input logic [1:0] op, input logic [3:0] r,
                           input logic [7:0] d, input int exp_lat, input string tag,
                           output int acc);
        int n;
        issue(s, op, r, d, acc);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cmd_ready_sel && n < 200);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [1:0] m,
                            input logic [7:0] d);
        if (idx < wlog.size()) begin
            check(tag, {22'd0, wlog[idx].mode, wlog[idx].data}, {22'd0, m, d});
        end else begin
            check({tag, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int acc, b, c, k, lows, n, prev_at;
        int vacc[3];
        logic [7:0] vals[3];
        vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ready", ready1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_mode", mode1, 2'b11);
        check("rst_wdata", wdata1, 8'h00);
        check("rst_strobes", {write1, read1}, 2'b00);
        check("rst_rsp", {rsp_valid1, rsp_data1}, 9'h000);
        @(negedge clk);
        reset = 1'b0;
        #1 check("ready_before_edge", ready1, 1'b0);
        @(posedge clk);
        #1 check("ready_after_release", ready1, 1'b1);

        // Register write, reg >= 4: two phases, no gap
        b = wlog.size();
        run_cmd(0, 2'b00, 4'h4, 8'h3C, 8, "reg4", acc);
        check("reg4_nwr", 32'(wlog.size() - b), 32'd2);
        check_wr("reg4_ph_a", b, 2'b00, 8'h04);
        check_wr("reg4_ph_b", b + 1, 2'b01, 8'h3C);
        if (wlog.size() >= b + 2) begin
            check("reg4_ph_a_at", 32'(wlog[b].at - acc), 32'd3);
            check("reg4_ph_b_at", 32'(wlog[b + 1].at - acc), 32'd7);
        end

        // Address setup with reg 0/1 (gap) then three VRAM writes
        b = wlog.size();
        run_cmd(0, 2'b00, 4'h0, 8'h10, 24, "reg0", acc);
        run_cmd(0, 2'b00, 4'h1, 8'h00, 24, "reg1", acc);
        check_wr("reg0_ph_b", b + 1, 2'b01, 8'h10);
        check_wr("reg1_ph_a", b + 2, 2'b00, 8'h01);
        b = wlog.size();
        for (int i = 0; i < 3; i++) begin
            run_cmd(0, 2'b01, 4'h0, vals[i], 20, "vwr", vacc[i]);
        end
        check("vwr_nwr", 32'(wlog.size() - b), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_wr("vwr_data", b + i, 2'b10, vals[i]);
        end
        if (wlog.size() >= b + 3) begin
            check("vwr_fall_at", 32'(wlog[b].at - vacc[0]), 32'd3);
            check("vwr_spacing01", 32'(wlog[b + 1].at - wlog[b].at >= 20), 32'd1);
            check("vwr_spacing12", 32'(wlog[b + 2].at - wlog[b + 1].at >= 20), 32'd1);
        end

        // VRAM reads
        run_cmd(0, 2'b00, 4'h3, 8'h02, 24, "reg3", acc);
        run_cmd(0, 2'b00, 4'h2, 8'h00, 24, "reg2", acc);
        b = wlog.size();
        rd_val1 = 8'h5A;
        c = rsp_cnt1;
        run_cmd(0, 2'b10, 4'h0, 8'h00, 20, "rd0", acc);
        check("rd0_pulses", 32'(rsp_cnt1 - c), 32'd1);
        check("rd0_data", rsp_data1, 8'h5A);
        check("rd0_rsp_at", 32'(rsp_at1 - acc), 32'd3);
        rd_val1 = 8'hA5;
        c = rsp_cnt1;
        run_cmd(0, 2'b10, 4'h0, 8'h00, 20, "rd1", acc);
        check("rd1_pulses", 32'(rsp_cnt1 - c), 32'd1);
        check("rd1_data", rsp_data1, 8'hA5);
        check("rd_no_writes", 32'(wlog.size() - b), 32'd0);

        // cmd_valid held with four queued register selects
        b = wlog.size();
        @(negedge clk);
        sel = 1'b0; cmd_valid = 1'b1;
        k = 0; lows = 0; n = 0;
        while (k < 4 && n < 200) begin
            if (ready1) begin
                cmd_op  = 2'b11;
                cmd_reg = 4'(5 + k);
                if (k > 0) check("queue_ready_low", 32'(lows), 32'd4);
                lows = 0;
                @(posedge clk);
                #1;
                k++;
                if (k == 4) cmd_valid = 1'b0;
            end else begin
                lows++;
                cmd_op   = 2'($urandom);
                cmd_reg  = 4'($urandom);
                cmd_data = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        check("queue_accepts", 32'(k), 32'd4);
        n = 0;
        while (!ready1 && n < 50) begin @(negedge clk); n++; end
        check("queue_nwr", 32'(wlog.size() - b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_wr("queue_sel", b + i, 2'b00, 8'(5 + i));
        end

        // Reset during the strobe of a VRAM write
        b = wlog.size();
        c = rsp_cnt1;
        issue(0, 2'b01, 4'h0, 8'h99, acc);
        @(posedge clk);
        #1 check("abort_strobe_on", write1, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("abort_write", write1, 1'b0);
        check("abort_mode", mode1, 2'b11);
        check("abort_wdata", wdata1, 8'h00);
        check("abort_busy", busy1, 1'b0);
        check("abort_ready", ready1, 1'b0);
        check("abort_rsp", rsp_valid1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 check("abort_ready_after", ready1, 1'b1);
        check("abort_no_wr", 32'(wlog.size() - b), 32'd0);
        check("abort_no_rsp", 32'(rsp_cnt1 - c), 32'd0);
        run_cmd(0, 2'b00, 4'h6, 8'h77, 8, "post_abort", acc);
        check_wr("post_abort_a", b, 2'b00, 8'h06);
        check_wr("post_abort_b", b + 1, 2'b01, 8'h77);

        // SETUP_CYCLES=2, STROBE_CYCLES=1 instance
        run_cmd(1, 2'b01, 4'h0, 8'h42, 20, "p2_vwr", acc);
        run_cmd(1, 2'b00, 4'h7, 8'h11, 8, "p2_reg7", acc);
        rd_val2 = 8'h3D;
        c = rsp_cnt2;
        run_cmd(1, 2'b10, 4'h0, 8'h00, 20, "p2_rd", acc);
        check("p2_rd_pulses", 32'(rsp_cnt2 - c), 32'd1);
        check("p2_rd_data", rsp_data2, 8'h3D);
        check("p2_rd_rsp_at", 32'(rsp_at2 - acc), 32'd3);

        check("bus_rules", 32'(bad_bus), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
